hams_sort_drain: RTL
====================

Name: hams_sort_drain

Overview:
- Receive-side endpoint for the merge-sort output stream: consumes sorted pairs plus the sorter's done indication.
- Buffers pairs in a local FIFO and presents them to a downstream consumer over valid/ready.
- Checks ordering and element count, and drives the sorter's pause input for backpressure, since the sorter has no ready input.
- Sits between the sorter top and the host or result memory.

Parameters:
- FIFO_DEPTH, 8, skid FIFO entries; power of two, at least 4.
- PAUSE_THRESH, FIFO_DEPTH-2, occupancy at or above which pause is asserted.
- CNT_WIDTH, 16, width of element counters.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse that arms a new run
- expected_count  in  CNT_WIDTH  number of pairs expected; sampled on start
- sorted_data  in  $bits(pair)  sorted pair from the sorter (pair from hams_pkg; ordering uses the .key field, unsigned)
- sorted_data_vld  in  1  sorted_data valid this cycle; cannot be stalled
- sorter_done  in  1  sorter finished; level or pulse
- pause  out  1  backpressure to the sorter
- out_data  out  $bits(pair)  head of FIFO
- out_vld  out  1  out_data valid
- out_rdy  in  1  downstream accepts
- elem_count  out  CNT_WIDTH  pairs accepted this run
- order_err  out  1  sticky: a key decreased
- first_err_idx  out  CNT_WIDTH  elem_count value of the first offending pair
- count_err  out  1  at DONE, elem_count differs from the latched expected_count
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- busy  out  1  state is RUN or FLUSH
- done  out  1  state is DONE

Behaviour:
- Reset (rst=1 on a clk edge):
  - State goes to IDLE and the FIFO is emptied.
  - All outputs are 0: pause, out_vld, out_data, elem_count, order_err, first_err_idx, count_err, overflow, busy, done.
  - Reset applied mid-run aborts the run; nothing is retained.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE/DONE -> RUN on start. Entering RUN:
    - clears elem_count, errors and the previous-key register;
    - latches expected_count;
    - empties the FIFO.
  - RUN -> FLUSH on sorter_done=1. A pair valid in that same cycle is still accepted.
  - FLUSH -> DONE when the FIFO is empty and no pop is pending.
  - On the FLUSH -> DONE transition, count_err is set to (elem_count != latched expected).
  - DONE holds done=1 until the next start.
  - start in RUN or FLUSH is ignored.
- Accept:
  - A pair is accepted only in RUN when sorted_data_vld=1.
  - sorted_data_vld outside RUN is ignored and is not counted.
- Push and counting:
  - An accepted pair is pushed to the FIFO.
  - elem_count increments by 1 and saturates at all-ones.
- Full FIFO:
  - If the FIFO is full and no pop occurs that cycle, the pair is dropped and overflow is set sticky.
  - The pair is still counted and still order-checked.
  - Push and pop in the same cycle at full: the push is accepted, with no overflow.
- Ordering check:
  - The first pair of a run is not checked.
  - Each later pair is compared with the previous accepted pair; key < prev_key is an error. Equal keys are legal.
  - On the first error only: order_err is set and first_err_idx captures elem_count before its increment (0-based index).
- FIFO:
  - Output is first-word-fall-through, with out_vld = !empty.
  - A pop occurs when out_vld && out_rdy.
  - Latency is 1 cycle from an accepted push to out_vld, including when the FIFO was empty. There is no combinational bypass.
  - out_data holds stable while out_vld=1 and out_rdy=0.
- Pause:
  - Registered: pause = (occupancy_next >= PAUSE_THRESH) while in RUN; 0 in other states.
  - The 2-entry margin absorbs the sorter's pause-response latency.
- Counter widths: occupancy counter is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Normal run:
  - Stimulus: start, expected_count=8; keys 1,2,3,3,5,8,9,12 on consecutive cycles; out_rdy=1; sorter_done after the last pair.
  - Required: out_data keys are the same 8 values in order; elem_count=8; order_err=0, count_err=0, overflow=0; done=1 one cycle after the FIFO drains.
- Order violation:
  - Stimulus: keys 4,7,6,9,2.
  - Required: order_err=1 and first_err_idx=2, with first_err_idx unchanged after key 2; all 5 pairs are output.
- Backpressure:
  - Stimulus: FIFO_DEPTH=8, out_rdy=0, 7 pairs pushed.
  - Required: pause rises on the clock edge at which occupancy reaches 6; the 7th pair is stored; overflow=0.
  - With out_rdy then set to 1: pause drops once occupancy < 6.
- Overflow:
  - Stimulus: out_rdy=0 with 10 pushes, ignoring pause.
  - Required: 8 stored; overflow=1; elem_count=10.
  - Full FIFO with simultaneous push and pop: no overflow.
- Count mismatch, mid-run start and reset:
  - Stimulus: expected_count=5 with only 4 pairs, then done.
  - Required: count_err=1 in DONE.
  - start during RUN: ignored.
  - rst mid-FLUSH: all outputs 0 and state IDLE next cycle; a following start and run behaves normally.

Source files
------------

// File: rtl/hams_sort_drain.sv
// Receive-side drain for the merge-sort stream: skid FIFO toward a valid/ready
// consumer, ordering/count checks, and pause backpressure to the sorter.
package hams_pkg;
   typedef struct packed {
      logic [15:0] key;
      logic [15:0] val;
   } pair;
endpackage

module hams_sort_drain
   import hams_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int PAUSE_THRESH = FIFO_DEPTH - 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] expected_count,
   input  pair                  sorted_data,
   input  logic                 sorted_data_vld,
   input  logic                 sorter_done,
   output logic                 pause,
   output pair                  out_data,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [CNT_WIDTH-1:0] elem_count,
   output logic                 order_err,
   output logic [CNT_WIDTH-1:0] first_err_idx,
   output logic                 count_err,
   output logic                 overflow,
   output logic                 busy,
   output logic                 done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t               r_state;
   pair                  r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [OW-1:0]        r_occ;
   logic [CNT_WIDTH-1:0] r_exp;
   logic [CNT_WIDTH-1:0] r_elem_cnt;
   logic [CNT_WIDTH-1:0] r_first_err;
   logic [15:0]          r_prev_key;
   logic                 r_have_prev;
   logic                 r_order_err;
   logic                 r_count_err;
   logic                 r_overflow;
   logic                 r_pause;

   logic                 w_start_run;
   logic                 w_accept;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [OW-1:0]        w_occ_nxt;

   assign w_start_run = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_accept    = (r_state == S_RUN) && sorted_data_vld;
   assign w_empty     = (r_occ == '0);
   assign w_full      = (r_occ == OW'(FIFO_DEPTH));
   assign w_pop       = !w_empty && out_rdy;
   // A pop on the same edge frees the slot, so a push at full still lands.
   assign w_push      = w_accept && (!w_full || w_pop);
   assign w_drop      = w_accept && w_full && !w_pop;
   assign w_occ_nxt   = r_occ + OW'(w_push) - OW'(w_pop);

   // FIFO storage and pointers; a new run discards anything left behind.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= sorted_data;
   end

   always_ff @(posedge clk) begin
      if (rst || w_start_run) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         r_occ <= w_occ_nxt;
      end
   end

   // Run control, checks and pause.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_exp       <= '0;
         r_elem_cnt  <= '0;
         r_first_err <= '0;
         r_prev_key  <= '0;
         r_have_prev <= 1'b0;
         r_order_err <= 1'b0;
         r_count_err <= 1'b0;
         r_overflow  <= 1'b0;
         r_pause     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state     <= S_RUN;
                  r_exp       <= expected_count;
                  r_elem_cnt  <= '0;
                  r_first_err <= '0;
                  r_prev_key  <= '0;
                  r_have_prev <= 1'b0;
                  r_order_err <= 1'b0;
                  r_count_err <= 1'b0;
                  r_overflow  <= 1'b0;
               end
            end
            S_RUN: begin
               if (sorter_done)
                  r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (w_empty) begin
                  r_state     <= S_DONE;
                  r_count_err <= (r_elem_cnt != r_exp);
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_accept) begin
            if (r_elem_cnt != '1)
               r_elem_cnt <= r_elem_cnt + CNT_WIDTH'(1);
            if (r_have_prev && (sorted_data.key < r_prev_key) && !r_order_err) begin
               r_order_err <= 1'b1;
               r_first_err <= r_elem_cnt;
            end
            r_prev_key  <= sorted_data.key;
            r_have_prev <= 1'b1;
            if (w_drop)
               r_overflow <= 1'b1;
         end

         // Pause only while the run continues; start always empties the FIFO.
         r_pause <= (r_state == S_RUN) && !sorter_done &&
                    (w_occ_nxt >= OW'(PAUSE_THRESH));
      end
   end

   assign pause         = r_pause;
   assign out_vld       = !w_empty;
   assign out_data      = w_empty ? '0 : r_mem[r_rptr];
   assign elem_count    = r_elem_cnt;
   assign order_err     = r_order_err;
   assign first_err_idx = r_first_err;
   assign count_err     = r_count_err;
   assign overflow      = r_overflow;
   assign busy          = (r_state == S_RUN) || (r_state == S_FLUSH);
   assign done          = (r_state == S_DONE);

endmodule
